weight_bram_sequencer: RTL and testbench
========================================

// Module: weight_bram_sequencer
// PURPOSE
//  Sequences one per-neuron weight BRAM (DEPTH x DW, read on negedge CLK, EN/WE/ADDR/DI/DO).
//  Arbitrates the BRAM between two requesters: the host weight loader (single-word writes)
//  and the neuron MAC engine (burst read of all DEPTH weights).
//  The BRAM ports connect directly to this block; one instance per neuron.
// PARAMETERS
//  DEPTH  28  number of weights per neuron (BRAM words 0..DEPTH-1)
//  AW     5   BRAM address width; requires DEPTH <= 2**AW
//  DW     16  weight word width
// PORTS
//  CLK        in   1   system clock; all state on posedge
//  RST        in   1   synchronous, active-high reset
//  START      in   1   MAC engine requests a burst read (pulse or level)
//  LD_REQ     in   1   loader write request
//  LD_ADDR    in   AW  loader target address
//  LD_DATA    in   DW  loader write data
//  LD_ACK     out  1   one-cycle pulse: write issued this cycle
//  LD_ERR     out  1   one-cycle pulse: LD_ADDR >= DEPTH, write dropped
//  BRAM_EN    out  1   to BRAM EN
//  BRAM_WE    out  1   to BRAM WE
//  BRAM_ADDR  out  AW  to BRAM ADDR
//  BRAM_DI    out  DW  to BRAM DI
//  BRAM_DO    in   DW  from BRAM DO
//  W_OUT      out  DW  weight stream to MAC
//  W_VALID    out  1   W_OUT valid this cycle
//  W_LAST     out  1   with W_VALID: last weight (index DEPTH-1)
//  BUSY       out  1   burst in progress (START ignored while high)
//  DONE       out  1   one-cycle pulse the cycle after the W_LAST beat
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; address counter 0. RST mid-burst aborts immediately,
//   no further W_VALID or DONE.
//  All BRAM_* outputs are registered (driven on posedge).
//  BRAM read timing: address driven at posedge t; BRAM captures at negedge;
//   BRAM_DO sampled at posedge t+1. Read latency is 1 cycle.
//  FSM states: IDLE, WRITE, READ, DRAIN, FIN.
//   IDLE: START -> READ (priority over LD_REQ when both are high in the same cycle).
//    Otherwise LD_REQ -> WRITE.
//   WRITE (1 cycle): EN=1, WE=1, ADDR=LD_ADDR, DI=LD_DATA; LD_ACK=1 -> IDLE.
//    If LD_ADDR >= DEPTH: EN=0, LD_ERR=1 instead, no LD_ACK -> IDLE.
//   READ: EN=1, WE=0, ADDR=cnt, where cnt runs 0..DEPTH-1, one per cycle, BUSY=1.
//    cnt==DEPTH-1 -> DRAIN.
//   DRAIN (1 cycle): EN=0; the last BRAM_DO is captured.
//   FIN (1 cycle): DONE=1, BUSY=0 -> IDLE. cnt is cleared to 0.
//  Stream: W_OUT/W_VALID are registered from BRAM_DO one cycle after the sampling edge.
//   So W_VALID first rises 2 cycles after READ entry.
//   W_VALID is high for exactly DEPTH consecutive cycles, in address order 0..DEPTH-1.
//   W_LAST coincides with index DEPTH-1. DONE follows in the next cycle.
//  LD_REQ during READ/DRAIN/FIN is held off (no ACK). The loader keeps LD_REQ, LD_ADDR and
//   LD_DATA stable until LD_ACK or LD_ERR.
//  After a WRITE, a back-to-back LD_REQ gets at most one write per 2 cycles
//   (each write passes through IDLE).
//  START asserted while BUSY is ignored. It is not queued.
//  cnt wraps nowhere: saturates at DEPTH-1, then resets in FIN.
// STRUCTURE
//  Shared package ann_pkg: DEPTH/AW/DW defaults and the state encoding localparams.
//  Single module, no sub-modules. Stream output stage is a plain register, not a FIFO.
//  The MAC does not backpressure the stream.
// TESTING
//  Reset: RST=1 for 3 cycles mid-stream -> all outputs 0, no DONE, next START streams from 0.
//  Load: write 28 words value 16'h0100+i to addr i.
//   Expect -> 28 LD_ACK pulses and a BRAM model holding the values.
//  Burst: START pulse.
//   Expect -> W_VALID for 28 cycles, W_OUT = 16'h0100..16'h011B in order.
//   W_LAST on the 28th beat, DONE next cycle, BUSY high from START+1 through the DRAIN cycle.
//  Conflict: START and LD_REQ in the same cycle -> burst runs first.
//   LD_ACK arrives 1 cycle after FIN. Streamed data is the pre-write value.
//  Bad address: LD_ADDR=30, LD_REQ=1 -> LD_ERR pulse, BRAM_EN stays 0, BRAM contents unchanged.
//  Restart: START held high continuously -> back-to-back bursts, each 28 beats.
//   DONE is pulsed between bursts; no beat is lost or duplicated.

Source files
------------

// File: rtl/weight_bram_sequencer_pkg.sv
// Shared defaults and FSM encoding for the per-neuron weight BRAM sequencer.
package weight_bram_sequencer_pkg;

  localparam int DEPTH_DEF = 28;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/weight_bram_sequencer_if.sv
// Loader, MAC stream and BRAM port bundle; master is the sequencer side.
interface weight_bram_sequencer_if
  import weight_bram_sequencer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          start;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ack;
  logic          ld_err;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_do;
  logic [DW-1:0] w_out;
  logic          w_valid;
  logic          w_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, ld_req, ld_addr, ld_data, bram_do,
    output ld_ack, ld_err, bram_en, bram_we, bram_addr, bram_di,
           w_out, w_valid, w_last, busy, done
  );

  modport slave (
    output start, ld_req, ld_addr, ld_data, bram_do,
    input  ld_ack, ld_err, bram_en, bram_we, bram_addr, bram_di,
           w_out, w_valid, w_last, busy, done
  );

endinterface

// File: rtl/weight_bram_sequencer.sv
// Arbitrates one weight BRAM between host single-word writes and a full
// DEPTH-word burst read streamed to the neuron MAC.
module weight_bram_sequencer
  import weight_bram_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input logic                     clk_i,
  input logic                     rst_i,
  weight_bram_sequencer_if.master wbs_io
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          bram_en_q, bram_en_d;
  logic          bram_we_q, bram_we_d;
  logic [AW-1:0] bram_addr_q, bram_addr_d;
  logic [DW-1:0] bram_di_q, bram_di_d;
  logic          ld_ack_q, ld_ack_d;
  logic          ld_err_q, ld_err_d;
  logic          busy_q, busy_d;
  logic          done_q;
  logic          ld_addr_ok;

  logic signed [DW-1:0] do_p1_q;
  logic                 vld_p1_q;
  logic                 last_p1_q;
  logic signed [DW-1:0] w_out_p2_q;
  logic                 vld_p2_q;
  logic                 last_p2_q;

  // Address counter holds at the last word instead of wrapping.
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == LAST_ADDR) ? v : v + AW'(1);
  endfunction

  assign ld_addr_ok = ({1'b0, wbs_io.ld_addr} < DEPTH_X);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_di_d   = bram_di_q;
    ld_ack_d    = 1'b0;
    ld_err_d    = 1'b0;
    busy_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wbs_io.start) begin
          state_d     = ST_READ;
          cnt_d       = '0;
          bram_en_d   = 1'b1;
          bram_addr_d = '0;
          busy_d      = 1'b1;
        end else if (wbs_io.ld_req) begin
          state_d     = ST_WRITE;
          bram_en_d   = ld_addr_ok;
          bram_we_d   = ld_addr_ok;
          bram_addr_d = wbs_io.ld_addr;
          bram_di_d   = wbs_io.ld_data;
          ld_ack_d    = ld_addr_ok;
          ld_err_d    = ~ld_addr_ok;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        // Next-cycle BUSY covers the DRAIN cycle that follows the last address.
        busy_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d       = sat_inc(cnt_q);
          bram_en_d   = 1'b1;
          bram_addr_d = cnt_d;
        end
      end
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
      ld_ack_q    <= 1'b0;
      ld_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q   <= bram_di_d;
      ld_ack_q    <= ld_ack_d;
      ld_err_q    <= ld_err_d;
      busy_q      <= busy_d;
      // FIN lasts one cycle, so DONE lands right after the W_LAST beat.
      done_q      <= (state_q == ST_FIN);
    end
  end

  // p1: BRAM_DO sampled one cycle after a read address was presented
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= bram_en_q & ~bram_we_q;
      last_p1_q <= bram_en_q & ~bram_we_q & (bram_addr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge clk_i) begin
    do_p1_q <= wbs_io.bram_do;
  end

  // p2: registered weight stream to the MAC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      w_out_p2_q <= '0;
    end else begin
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
      if (vld_p1_q) begin
        w_out_p2_q <= do_p1_q;
      end
    end
  end

  assign wbs_io.ld_ack    = ld_ack_q;
  assign wbs_io.ld_err    = ld_err_q;
  assign wbs_io.bram_en   = bram_en_q;
  assign wbs_io.bram_we   = bram_we_q;
  assign wbs_io.bram_addr = bram_addr_q;
  assign wbs_io.bram_di   = bram_di_q;
  assign wbs_io.w_out     = w_out_p2_q;
  assign wbs_io.w_valid   = vld_p2_q;
  assign wbs_io.w_last    = last_p2_q;
  assign wbs_io.busy      = busy_q;
  assign wbs_io.done      = done_q;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Bench for weight_bram_sequencer: BRAM model, loader/MAC stimulus, stream scoreboard.
module tb_weight_bram_sequencer;
  import weight_bram_sequencer_pkg::*;

  localparam int DEPTH  = 28;
  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int NWORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  weight_bram_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wbs_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: reads and writes happen on the falling edge
  logic [DW-1:0] mem [NWORDS] = '{default: '0};
  always @(negedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_di;
      else             bus.bram_do <= mem[bus.bram_addr];
    end
  end

  logic [DW-1:0] ref_mem [NWORDS];

  logic [DW-1:0] beat_val [$];
  int            beat_cyc [$];
  bit            beat_last [$];
  int            done_cyc [$];
  always @(negedge clk) begin
    if (bus.w_valid) begin
      beat_val.push_back(bus.w_out);
      beat_cyc.push_back(cyc);
      beat_last.push_back(bus.w_last);
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            exp_ack;
    bit            exp_err;
  } wr_vec_t;
  wr_vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.ld_ack, bus.ld_err, bus.bram_en, bus.bram_we,
                               bus.w_valid, bus.w_last, bus.busy, bus.done}), 64'(0));
    check({tag, "_addr_di"}, 64'({bus.bram_addr, bus.bram_di}), 64'(0));
    check({tag, "_wout"}, 64'(bus.w_out), 64'(0));
  endtask

  task automatic check_mem(input string tag);
    @(posedge clk); #1;
    for (int i = 0; i < NWORDS; i++)
      check($sformatf("%s_mem%0d", tag, i), 64'(mem[i]), 64'(ref_mem[i]));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit exp_ack, input bit exp_err, input string tag,
                          output bit got_ack);
    bit seen;
    got_ack = 1'b0;
    seen    = 1'b0;
    @(posedge clk); #1;
    bus.ld_req  = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      if (bus.ld_ack || bus.ld_err) begin
        seen    = 1'b1;
        got_ack = bus.ld_ack;
        check({tag, "_ack"}, 64'(bus.ld_ack), 64'(exp_ack));
        check({tag, "_err"}, 64'(bus.ld_err), 64'(exp_err));
        check({tag, "_en"}, 64'(bus.bram_en), 64'(exp_ack));
        check({tag, "_latency"}, 64'(t), 64'(1));
        if (exp_ack)
          check({tag, "_we_addr_di"}, 64'({bus.bram_we, bus.bram_addr, bus.bram_di}),
                64'({1'b1, a, d}));
      end
    end
    bus.ld_req = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no LD_ACK/LD_ERR, want one within 6 cycles", tag);
    end
    if (exp_ack) ref_mem[a] = d;
  endtask

  // Caller raises START just after a posedge; the next posedge samples it (n counts from there).
  task automatic burst_check(input int ack_n, input string tag);
    @(posedge clk); #1 bus.start = 1'b0;
    for (int n = 0; n < 34; n++) begin
      @(negedge clk);
      check($sformatf("%s_busy_n%0d", tag, n), 64'(bus.busy), 64'(n <= DEPTH));
      check($sformatf("%s_en_n%0d", tag, n), 64'(bus.bram_en), 64'((n < DEPTH) || (n == ack_n)));
      check($sformatf("%s_valid_n%0d", tag, n), 64'(bus.w_valid), 64'(n >= 2 && n <= DEPTH + 1));
      check($sformatf("%s_last_n%0d", tag, n), 64'(bus.w_last), 64'(n == DEPTH + 1));
      check($sformatf("%s_done_n%0d", tag, n), 64'(bus.done), 64'(n == DEPTH + 2));
      if (n >= 2 && n <= DEPTH + 1)
        check($sformatf("%s_wout_n%0d", tag, n), 64'(bus.w_out), 64'(ref_mem[n-2]));
      if (ack_n >= 0) begin
        check($sformatf("%s_ldack_n%0d", tag, n), 64'(bus.ld_ack), 64'(n == ack_n));
        if (n == ack_n) bus.ld_req = 1'b0;
      end
    end
  endtask

  int            acks, b0, d0, nb, nd, nw, idx;
  bit            got;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'd3,  16'hA5A5, 1'b1, 1'b0};
    tbl[1] = '{5'd27, 16'h7FFF, 1'b1, 1'b0};
    tbl[2] = '{5'd28, 16'h1234, 1'b0, 1'b1};
    tbl[3] = '{5'd30, 16'hDEAD, 1'b0, 1'b1};
    tbl[4] = '{5'd31, 16'h5555, 1'b0, 1'b1};
    tbl[5] = '{5'd0,  16'h8000, 1'b1, 1'b0};

    bus.start   = 1'b0;
    bus.ld_req  = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_zero($sformatf("reset_init%0d", i));
    end
    rst = 1'b0;

    acks = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), DW'(16'h0100 + i), 1'b1, 1'b0, $sformatf("load%0d", i), got);
      acks += int'(got);
    end
    check("load_ack_count", 64'(acks), 64'(DEPTH));
    check_mem("load");

    @(posedge clk); #1 bus.start = 1'b1;
    burst_check(-1, "burst");

    for (int i = 0; i < 6; i++)
      do_write(tbl[i].addr, tbl[i].data, tbl[i].exp_ack, tbl[i].exp_err,
               $sformatf("tbl%0d", i), got);
    check_mem("tbl");

    // START and LD_REQ together: burst streams the old word 5, write follows.
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.ld_req  = 1'b1;
    bus.ld_addr = 5'd5;
    bus.ld_data = 16'hBEEF;
    burst_check(DEPTH + 3, "conflict");
    bus.ld_req  = 1'b0;
    ref_mem[5] = 16'hBEEF;
    check_mem("conflict");

    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_zero($sformatf("reset_mid%0d", i));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    b0 = beat_val.size();
    d0 = done_cyc.size();
    repeat (40) @(posedge clk);
    #1;
    check("reset_no_beats", 64'(beat_val.size() - b0), 64'(0));
    check("reset_no_done", 64'(done_cyc.size() - d0), 64'(0));
    bus.start = 1'b1;
    burst_check(-1, "post_reset");

    // START held high: three bursts sampled 31 cycles apart.
    @(posedge clk); #1;
    b0 = beat_val.size();
    d0 = done_cyc.size();
    bus.start = 1'b1;
    repeat (63) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    nb = beat_val.size() - b0;
    nd = done_cyc.size() - d0;
    check("restart_beats", 64'(nb), 64'(3 * DEPTH));
    check("restart_dones", 64'(nd), 64'(3));
    if (nb == 3 * DEPTH && nd == 3) begin
      for (int g = 0; g < 3; g++) begin
        for (int i = 0; i < DEPTH; i++) begin
          idx = b0 + g * DEPTH + i;
          check($sformatf("restart_g%0d_val%0d", g, i), 64'(beat_val[idx]), 64'(ref_mem[i]));
          check($sformatf("restart_g%0d_last%0d", g, i), 64'(beat_last[idx]), 64'(i == DEPTH - 1));
          check($sformatf("restart_g%0d_cyc%0d", g, i), 64'(beat_cyc[idx]),
                64'(beat_cyc[b0 + g * DEPTH] + i));
        end
        check($sformatf("restart_g%0d_done", g), 64'(done_cyc[d0 + g]),
              64'(beat_cyc[b0 + g * DEPTH + DEPTH - 1] + 1));
      end
    end

    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(2, 6);
      for (int w = 0; w < nw; w++) begin
        ra = AW'($urandom_range(0, NWORDS - 1));
        rd = DW'($urandom);
        do_write(ra, rd, int'(ra) < DEPTH, int'(ra) >= DEPTH, $sformatf("rand%0d_w%0d", r, w), got);
      end
      @(posedge clk); #1 bus.start = 1'b1;
      burst_check(-1, $sformatf("rand%0d", r));
    end
    check_mem("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
